// File: rtl/spi_cs_pkg.sv
// ============================================================================
// Module   : spi_cs_pkg
// Brief    : State encoding and count-width helper for the SPI CS sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_cs_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE        = 2'd0;
    localparam state_t ST_SETUP       = 2'd1;
    localparam state_t ST_TRANSFER    = 2'd2;
    localparam state_t ST_CS_INACTIVE = 2'd3;

    // Bits needed to hold values 0..max_value, never less than one.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_cs_gap_timer.sv
// ============================================================================
// Module   : spi_cs_gap_timer
// Brief    : Loadable down-counter timing the CS setup and CS inactive gaps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cs_gap_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

`default_nettype wire

// File: rtl/spi_cs_sequencer.sv
// ============================================================================
// Module   : spi_cs_sequencer
// Brief    : Frames byte-level SPI master traffic with chip select; optional
//            CS-to-first-byte setup delay when SPI_CS_SETUP_DELAY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_cs_sequencer
    import spi_cs_pkg::*;
#(
    parameter  int MAX_BYTES_PER_CS = 2,
    parameter  int CS_INACTIVE_CLKS = 1,
    parameter  int CS_SETUP_CLKS    = 2,
    localparam int CW               = count_width(MAX_BYTES_PER_CS)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [7:0]    o_M_TX_Byte,
    output logic          o_M_TX_DV,
    input  logic          i_M_TX_Ready,
    input  logic          i_M_RX_DV,
    input  logic [7:0]    i_M_RX_Byte,
    output logic          o_SPI_CS_n
);

    // One timer serves both gaps, so it is sized for the longer of the two.
    localparam int GAP_MAX = (CS_INACTIVE_CLKS > CS_SETUP_CLKS) ? CS_INACTIVE_CLKS : CS_SETUP_CLKS;
    localparam int TW      = count_width(GAP_MAX);
    localparam logic [TW-1:0] INACTIVE_LOAD = TW'((CS_INACTIVE_CLKS < 1) ? 0 : CS_INACTIVE_CLKS - 1);
`ifdef SPI_CS_SETUP_DELAY_EN
    localparam logic [TW-1:0] SETUP_LOAD    = TW'((CS_SETUP_CLKS < 1) ? 0 : CS_SETUP_CLKS - 1);
`endif

    state_t        state;
    logic [CW-1:0] remaining;
    logic          in_flight;
    logic          m_tx_dv;
    logic [7:0]    m_tx_byte;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [CW-1:0] rx_count;
    logic          cs_n;

    logic          tx_ready;
    logic          accept;
    logic          rx_take;
    logic          to_inactive;
    logic [CW-1:0] first_count;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          timer_done;

    assign tx_ready    = !i_Rst && i_M_TX_Ready && !in_flight &&
                         ((state == ST_IDLE) || ((state == ST_TRANSFER) && (remaining != '0)));
    assign accept      = tx_ready && i_TX_DV;
    assign rx_take     = i_M_RX_DV && (state == ST_TRANSFER) && in_flight;
    assign to_inactive = (state == ST_TRANSFER) && (remaining == '0) && !in_flight && i_M_TX_Ready;

    always_comb begin
        if (i_TX_Count == '0) begin
            first_count = CW'(1);
        end else if (i_TX_Count > CW'(MAX_BYTES_PER_CS)) begin
            first_count = CW'(MAX_BYTES_PER_CS);
        end else begin
            first_count = i_TX_Count;
        end
    end

    always_comb begin
        timer_load  = 1'b0;
        timer_value = INACTIVE_LOAD;
        if (to_inactive) begin
            timer_load = 1'b1;
        end
`ifdef SPI_CS_SETUP_DELAY_EN
        if ((state == ST_IDLE) && accept) begin
            timer_load  = 1'b1;
            timer_value = SETUP_LOAD;
        end
`endif
    end

    spi_cs_gap_timer #(
        .WIDTH (TW)
    ) u_gap_timer (
        .clk        (i_Clk),
        .rst        (i_Rst),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            in_flight <= 1'b0;
            m_tx_dv   <= 1'b0;
            m_tx_byte <= 8'h00;
            rx_dv     <= 1'b0;
            rx_byte   <= 8'h00;
            rx_count  <= '0;
            cs_n      <= 1'b1;
        end else begin
            m_tx_dv <= 1'b0;
            rx_dv   <= 1'b0;
            if (rx_dv) begin
                rx_count <= rx_count + 1'b1;
            end
            if (rx_take) begin
                in_flight <= 1'b0;
                rx_dv     <= 1'b1;
                rx_byte   <= i_M_RX_Byte;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // The byte accepted here counts against the transaction total.
                        remaining <= first_count - 1'b1;
                        m_tx_byte <= i_TX_Byte;
                        in_flight <= 1'b1;
                        cs_n      <= 1'b0;
                        rx_count  <= '0;
`ifdef SPI_CS_SETUP_DELAY_EN
                        state     <= ST_SETUP;
`else
                        state     <= ST_TRANSFER;
                        m_tx_dv   <= 1'b1;
`endif
                    end
                end
`ifdef SPI_CS_SETUP_DELAY_EN
                ST_SETUP: begin
                    if (timer_done) begin
                        state   <= ST_TRANSFER;
                        m_tx_dv <= 1'b1;
                    end
                end
`endif
                ST_TRANSFER: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        m_tx_byte <= i_TX_Byte;
                        in_flight <= 1'b1;
                        m_tx_dv   <= 1'b1;
                    end else if (to_inactive) begin
                        state <= ST_CS_INACTIVE;
                        cs_n  <= 1'b1;
                    end
                end
                ST_CS_INACTIVE: begin
                    if (timer_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_TX_Ready  = tx_ready;
    assign o_RX_Count  = rx_count;
    assign o_RX_DV     = rx_dv;
    assign o_RX_Byte   = rx_byte;
    assign o_M_TX_Byte = m_tx_byte;
    assign o_M_TX_DV   = m_tx_dv;
    assign o_SPI_CS_n  = cs_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_cs_sequencer.sv
// ============================================================================
// Module   : tb_spi_cs_sequencer
// Brief    : Directed self-checking bench for spi_cs_sequencer with a loopback
//            byte-level SPI master model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_cs_sequencer;

    localparam int MAXB  = 2;
    localparam int INACT = 3;
    localparam int SETUP = 4;
    localparam int CW    = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          i_Rst = 1'b0;
    logic [CW-1:0] i_TX_Count = '0;
    logic [7:0]    i_TX_Byte = 8'h00;
    logic          i_TX_DV = 1'b0;
    logic          o_TX_Ready;
    logic [CW-1:0] o_RX_Count;
    logic          o_RX_DV;
    logic [7:0]    o_RX_Byte;
    logic [7:0]    o_M_TX_Byte;
    logic          o_M_TX_DV;
    logic          m_ready = 1'b1;
    logic          m_rx_dv = 1'b0;
    logic [7:0]    m_rx_byte = 8'h00;
    logic          o_SPI_CS_n;

    int vectors = 0;
    int miscompares = 0;
    int mtx_pulses = 0;
    int rx_pulses = 0;

    always #5 clk = ~clk;

    spi_cs_sequencer #(
        .MAX_BYTES_PER_CS (MAXB),
        .CS_INACTIVE_CLKS (INACT),
        .CS_SETUP_CLKS    (SETUP)
    ) dut (
        .i_Clk        (clk),
        .i_Rst        (i_Rst),
        .i_TX_Count   (i_TX_Count),
        .i_TX_Byte    (i_TX_Byte),
        .i_TX_DV      (i_TX_DV),
        .o_TX_Ready   (o_TX_Ready),
        .o_RX_Count   (o_RX_Count),
        .o_RX_DV      (o_RX_DV),
        .o_RX_Byte    (o_RX_Byte),
        .o_M_TX_Byte  (o_M_TX_Byte),
        .o_M_TX_DV    (o_M_TX_DV),
        .i_M_TX_Ready (m_ready),
        .i_M_RX_DV    (m_rx_dv),
        .i_M_RX_Byte  (m_rx_byte),
        .o_SPI_CS_n   (o_SPI_CS_n)
    );

    always @(negedge clk) begin
        if (o_M_TX_DV === 1'b1) mtx_pulses++;
        if (o_RX_DV === 1'b1) rx_pulses++;
    end

    // Loopback master: busy for two cycles, then returns the sent byte.
    initial begin
        logic [7:0] lb;
        forever begin
            @(negedge clk);
            if (o_M_TX_DV === 1'b1) begin
                lb = o_M_TX_Byte;
                m_ready = 1'b0;
                repeat (2) @(negedge clk);
                m_rx_byte = lb;
                m_rx_dv = 1'b1;
                m_ready = 1'b1;
                @(negedge clk);
                m_rx_dv = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [CW-1:0] c);
        int n;
        n = 0;
        while (o_TX_Ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            vectors++; miscompares++;
            $display("FAIL send_wait: o_TX_Ready=%b required 1 within 60 cycles", o_TX_Ready);
        end
        i_TX_DV = 1'b1; i_TX_Byte = b; i_TX_Count = c;
        step();
        i_TX_DV = 1'b0;
    endtask

    task automatic wait_rx();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (o_RX_DV !== 1'b1 && n < 60);
        if (o_RX_DV !== 1'b1) begin
            vectors++; miscompares++;
            $display("FAIL rx_wait: o_RX_DV=%b required 1 within 60 cycles", o_RX_DV);
        end
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        repeat (2) step();
        vectors++;
        if (o_SPI_CS_n !== 1'b1 || o_TX_Ready !== 1'b0 || o_M_TX_DV !== 1'b0 || o_RX_DV !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: cs_n=%b ready=%b mtx_dv=%b rx_dv=%b required 1 0 0 0",
                     o_SPI_CS_n, o_TX_Ready, o_M_TX_DV, o_RX_DV);
        end
        vectors++;
        if (o_M_TX_Byte !== 8'h00 || o_RX_Byte !== 8'h00 || o_RX_Count !== '0) begin
            miscompares++;
            $display("FAIL reset_data: mtx_byte=%h rx_byte=%h rx_count=%0d required 00 00 0",
                     o_M_TX_Byte, o_RX_Byte, o_RX_Count);
        end
        i_Rst = 1'b0;
        step();
        vectors++;
        if (o_TX_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: ready=%b required 1", o_TX_Ready);
        end
    endtask

    task automatic test_two_byte();
        int bm, br;
        bm = mtx_pulses; br = rx_pulses;
        send_byte(8'hA5, CW'(2));
        vectors++;
        if (o_SPI_CS_n !== 1'b0) begin
            miscompares++;
            $display("FAIL two_cs_fall: cs_n=%b required 0", o_SPI_CS_n);
        end
`ifndef SPI_CS_SETUP_DELAY_EN
        vectors++;
        if (o_M_TX_DV !== 1'b1 || o_M_TX_Byte !== 8'hA5) begin
            miscompares++;
            $display("FAIL two_first_mtx: mtx_dv=%b byte=%h required 1 a5", o_M_TX_DV, o_M_TX_Byte);
        end
`endif
        wait_rx();
        vectors++;
        if (o_RX_Byte !== 8'hA5 || o_RX_Count !== CW'(0) || o_SPI_CS_n !== 1'b0) begin
            miscompares++;
            $display("FAIL two_rx0: byte=%h count=%0d cs_n=%b required a5 0 0", o_RX_Byte, o_RX_Count, o_SPI_CS_n);
        end
        send_byte(8'h3C, CW'(2));
        wait_rx();
        vectors++;
        if (o_RX_Byte !== 8'h3C || o_RX_Count !== CW'(1) || o_SPI_CS_n !== 1'b0) begin
            miscompares++;
            $display("FAIL two_rx1: byte=%h count=%0d cs_n=%b required 3c 1 0", o_RX_Byte, o_RX_Count, o_SPI_CS_n);
        end
        step();
        vectors++;
        if (o_SPI_CS_n !== 1'b1 || o_TX_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL two_cs_rise: cs_n=%b ready=%b required 1 0", o_SPI_CS_n, o_TX_Ready);
        end
        vectors++;
        if (mtx_pulses - bm != 2 || rx_pulses - br != 2) begin
            miscompares++;
            $display("FAIL two_pulses: mtx=%0d rx=%0d required 2 2", mtx_pulses - bm, rx_pulses - br);
        end
    endtask

    task automatic test_count_zero();
        int bm, br;
        bm = mtx_pulses; br = rx_pulses;
        send_byte(8'h81, CW'(0));
        wait_rx();
        vectors++;
        if (o_RX_Byte !== 8'h81 || o_RX_Count !== CW'(0)) begin
            miscompares++;
            $display("FAIL zero_rx: byte=%h count=%0d required 81 0", o_RX_Byte, o_RX_Count);
        end
        step();
        vectors++;
        if (o_SPI_CS_n !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_cs_rise: cs_n=%b required 1", o_SPI_CS_n);
        end
        vectors++;
        if (mtx_pulses - bm != 1 || rx_pulses - br != 1) begin
            miscompares++;
            $display("FAIL zero_pulses: mtx=%0d rx=%0d required 1 1", mtx_pulses - bm, rx_pulses - br);
        end
    endtask

    task automatic test_ignored_while_busy();
        int bm;
        bm = mtx_pulses;
        send_byte(8'h11, CW'(2));
        vectors++;
        if (o_TX_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ready: ready=%b required 0", o_TX_Ready);
        end
        i_TX_DV = 1'b1; i_TX_Byte = 8'hFF; i_TX_Count = CW'(1);
        step();
        i_TX_DV = 1'b0;
        vectors++;
        if (o_M_TX_DV !== 1'b0 || o_M_TX_Byte !== 8'h11) begin
            miscompares++;
            $display("FAIL busy_ignored: mtx_dv=%b byte=%h required 0 11", o_M_TX_DV, o_M_TX_Byte);
        end
        wait_rx();
        vectors++;
        if (o_RX_Byte !== 8'h11) begin
            miscompares++;
            $display("FAIL busy_rx0: byte=%h required 11", o_RX_Byte);
        end
        send_byte(8'h22, CW'(2));
        wait_rx();
        vectors++;
        if (o_RX_Byte !== 8'h22 || o_RX_Count !== CW'(1)) begin
            miscompares++;
            $display("FAIL busy_rx1: byte=%h count=%0d required 22 1", o_RX_Byte, o_RX_Count);
        end
        step();
        vectors++;
        if (o_SPI_CS_n !== 1'b1 || mtx_pulses - bm != 2) begin
            miscompares++;
            $display("FAIL busy_end: cs_n=%b mtx=%0d required 1 2", o_SPI_CS_n, mtx_pulses - bm);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        send_byte(8'hC3, CW'(1));
        wait_rx();
        step();
        n = 0;
        while (o_TX_Ready === 1'b0 && o_SPI_CS_n === 1'b1 && n < 20) begin
            n++;
            step();
        end
        vectors++;
        if (n != INACT || o_SPI_CS_n !== 1'b1 || o_TX_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_gap: gap=%0d cs_n=%b ready=%b required %0d 1 1", n, o_SPI_CS_n, o_TX_Ready, INACT);
        end
        send_byte(8'h3E, CW'(1));
        vectors++;
        if (o_SPI_CS_n !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_cs_fall: cs_n=%b required 0", o_SPI_CS_n);
        end
        wait_rx();
        vectors++;
        if (o_RX_Byte !== 8'h3E || o_RX_Count !== CW'(0)) begin
            miscompares++;
            $display("FAIL b2b_rx: byte=%h count=%0d required 3e 0", o_RX_Byte, o_RX_Count);
        end
        step();
    endtask

    task automatic test_setup_timing();
        int n, exp_n;
`ifdef SPI_CS_SETUP_DELAY_EN
        exp_n = SETUP;
`else
        exp_n = 0;
`endif
        send_byte(8'h77, CW'(1));
        vectors++;
        if (o_SPI_CS_n !== 1'b0) begin
            miscompares++;
            $display("FAIL setup_cs_fall: cs_n=%b required 0", o_SPI_CS_n);
        end
        n = 0;
        while (o_M_TX_DV !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vectors++;
        if (n != exp_n || o_M_TX_Byte !== 8'h77 || o_SPI_CS_n !== 1'b0) begin
            miscompares++;
            $display("FAIL setup_delay: cycles=%0d byte=%h cs_n=%b required %0d 77 0", n, o_M_TX_Byte, o_SPI_CS_n, exp_n);
        end
        wait_rx();
        step();
    endtask

    task automatic test_reset_mid();
        int seen;
        send_byte(8'h5A, CW'(2));
        i_Rst = 1'b1;
        step();
        vectors++;
        if (o_SPI_CS_n !== 1'b1 || o_M_TX_DV !== 1'b0 || o_RX_DV !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_cs: cs_n=%b mtx_dv=%b rx_dv=%b required 1 0 0", o_SPI_CS_n, o_M_TX_DV, o_RX_DV);
        end
        i_Rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_RX_DV === 1'b1 || o_M_TX_DV === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0 || o_RX_Count !== '0 || o_SPI_CS_n !== 1'b1 || o_TX_Ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_after: pulses=%0d rx_count=%0d cs_n=%b ready=%b required 0 0 1 1",
                     seen, o_RX_Count, o_SPI_CS_n, o_TX_Ready);
        end
    endtask

    initial begin
        test_reset();
        test_two_byte();
        test_count_zero();
        test_ignored_while_busy();
        test_back_to_back();
        test_setup_timing();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/spi_cs_sequencer.md
SPI_CS_SEQUENCER -- requirements
Module: spi_cs_sequencer

Interface
REQ-001 The block SHALL be parameterised by MAX_BYTES_PER_CS, default 2, meaning the maximum bytes sent per chip-select assertion.
REQ-002 The block SHALL be parameterised by CS_INACTIVE_CLKS, default 1, meaning the i_Clk cycles CS is held high between transactions.
REQ-003 The block SHALL be parameterised by CS_SETUP_CLKS, default 2, meaning the i_Clk cycles from CS assert to the first byte when setup delay is compiled in.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: i_Clk input 1 (clock), i_Rst input 1 (reset).
REQ-005 The block SHALL have ports: i_TX_Count input CW, bytes in this transaction, sampled with first i_TX_DV (CW = $clog2(MAX_BYTES_PER_CS+1)).
REQ-006 The block SHALL have ports: i_TX_Byte input 8 (byte to send); i_TX_DV input 1 (byte valid pulse); o_TX_Ready output 1 (next byte accepted).
REQ-007 The block SHALL have ports: o_RX_Count output CW (index of received byte); o_RX_DV output 1 (received-byte pulse); o_RX_Byte output 8 (received byte).
REQ-008 The block SHALL have ports: o_M_TX_Byte output 8; o_M_TX_DV output 1; i_M_TX_Ready input 1; i_M_RX_DV input 1; i_M_RX_Byte input 8 (byte-level SPI master side).
REQ-009 The block SHALL have port o_SPI_CS_n output 1, active-low chip select.

Function
REQ-010 States SHALL be IDLE, SETUP, TRANSFER, CS_INACTIVE.
REQ-011 o_TX_Ready SHALL be 1 only when (IDLE or TRANSFER) and i_M_TX_Ready=1 and no byte in flight and bytes-remaining>0 (IDLE counts as remaining>0).
REQ-012 i_TX_DV with o_TX_Ready=0 SHALL be ignored with no state change.
REQ-013 Accepted i_TX_DV in IDLE SHALL latch i_TX_Count as remaining (0 treated as 1, values >MAX_BYTES_PER_CS clamped to MAX_BYTES_PER_CS), latch the byte, drive o_SPI_CS_n=0 next cycle, clear o_RX_Count.
REQ-014 Without setup delay, IDLE SHALL go to TRANSFER and pulse o_M_TX_DV one cycle after acceptance, o_M_TX_Byte stable with it.
REQ-015 In TRANSFER each accepted byte SHALL pulse o_M_TX_DV for exactly one cycle one cycle after acceptance, decrement remaining, and set in-flight.
REQ-016 In-flight SHALL clear on i_M_RX_DV; o_RX_DV/o_RX_Byte SHALL follow i_M_RX_DV with 1-cycle latency; o_RX_Count SHALL increment after each o_RX_DV.
REQ-017 TRANSFER SHALL go to CS_INACTIVE when remaining=0, in-flight=0, and i_M_TX_Ready=1; o_SPI_CS_n SHALL be 1 from the next cycle.
REQ-018 CS_INACTIVE SHALL hold o_SPI_CS_n=1 and o_TX_Ready=0 for exactly CS_INACTIVE_CLKS cycles (0 meaning 1), then return to IDLE.
REQ-019 i_M_RX_DV outside TRANSFER or with in-flight=0 SHALL be dropped.

Reset
REQ-020 On i_Rst=1 at a rising i_Clk, the block SHALL enter IDLE with o_SPI_CS_n=1, o_TX_Ready=0, o_M_TX_DV=0, o_RX_DV=0, o_M_TX_Byte=0, o_RX_Byte=0, o_RX_Count=0, remaining=0, in-flight=0.
REQ-021 Reset mid-transaction SHALL deassert CS the next cycle and emit no further DV pulses; o_TX_Ready SHALL return to 1 the first cycle after reset release with i_M_TX_Ready=1.

Configuration
REQ-022 Macro SPI_CS_SETUP_DELAY_EN defined: IDLE SHALL go to SETUP, holding CS low CS_SETUP_CLKS cycles (0 meaning 1) before the first o_M_TX_DV.
REQ-023 Macro SPI_CS_SETUP_DELAY_EN undefined: SETUP state and its counter SHALL not exist; REQ-014 applies; CS_SETUP_CLKS SHALL be ignored.

Structure
REQ-024 Package spi_cs_pkg SHALL hold the state enum and the count-width constant function.
REQ-025 Sub-module spi_cs_gap_timer SHALL implement the loadable down-counter shared by SETUP and CS_INACTIVE.

Verification
REQ-026 Count=2, bytes 0xA5,0x3C, master loopback -> CS low across both, o_RX_Byte 0xA5 (count 0) then 0x3C (count 1), CS high after.
REQ-027 Count=0, byte 0x81 -> exactly one o_M_TX_DV, one o_RX_DV, CS high after.
REQ-028 i_TX_DV with byte 0xFF while byte in flight -> ignored, no o_M_TX_DV, remaining unchanged.
REQ-029 CS_INACTIVE_CLKS=3, back-to-back transactions -> CS high exactly 3 cycles, o_TX_Ready=0 throughout.
REQ-030 i_Rst pulsed after first byte of count=2 -> CS=1 next cycle, no o_RX_DV, o_RX_Count=0.
REQ-031 SPI_CS_SETUP_DELAY_EN, CS_SETUP_CLKS=4 -> first o_M_TX_DV exactly 4 cycles after CS falls.
